// File: rtl/btn_event_pkg.sv
// Shared constants for the button event decoder: event codes and FSM state encoding.
package btn_event_pkg;

    localparam logic [1:0] EV_PRESS   = 2'd0;
    localparam logic [1:0] EV_RELEASE = 2'd1;
    localparam logic [1:0] EV_LONG    = 2'd2;
    localparam logic [1:0] EV_REPEAT  = 2'd3;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_PRESSED   = 2'd1;
    localparam logic [1:0] ST_LONG_HELD = 2'd2;

endpackage

// File: rtl/btn_hold_timer.sv
// Saturating hold counter with synchronous clear and a terminal-count compare.
module btn_hold_timer #(
    parameter int CNT_W = 25
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] terminal,
    output logic             tc
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Clear wins over enable; the count sticks at all-ones rather than wrapping.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == terminal);

endmodule

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into PRESS/RELEASE/LONG/REPEAT events in a one-entry buffer.
// REPEAT generation is built only when BTN_EVENT_REPEAT_EN is defined.
module button_event_decoder
    import btn_event_pkg::*;
#(
    parameter int unsigned LONG_CYCLES   = 19_000_000,
    parameter int unsigned REPEAT_CYCLES = 3_800_000,
    parameter int          CNT_W         = 25
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       db_in,
    input  logic       event_ready,
    output logic       event_valid,
    output logic [1:0] event_code,
    output logic       pressed,
    output logic       overflow
);

    localparam logic [CNT_W-1:0] LONG_TC   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_CYCLES - 1);

    logic       db_prev_q;
    logic [1:0] state_q, state_d;
    logic       ev_valid_q, ev_valid_d;
    logic [1:0] ev_code_q, ev_code_d;
    logic       pressed_q, pressed_d;
    logic       overflow_q, overflow_d;

    logic       rise, fall;
    logic       gen_valid;
    logic [1:0] gen_code;
    logic       tmr_clear, tmr_enable, tmr_tc;
    logic [CNT_W-1:0] tmr_terminal;

    assign rise = db_in & ~db_prev_q;
    assign fall = ~db_in & db_prev_q;

    assign tmr_terminal = (state_q == ST_PRESSED) ? LONG_TC : REPEAT_TC;

    btn_hold_timer #(
        .CNT_W(CNT_W)
    ) u_hold_timer (
        .clk     (clk),
        .n_reset (n_reset),
        .clear   (tmr_clear),
        .enable  (tmr_enable),
        .terminal(tmr_terminal),
        .tc      (tmr_tc)
    );

    // A falling edge always takes priority over a terminal count in the same cycle.
    always_comb begin
        state_d    = state_q;
        gen_valid  = 1'b0;
        gen_code   = EV_PRESS;
        tmr_clear  = 1'b0;
        tmr_enable = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tmr_clear = 1'b1;
                if (rise) begin
                    state_d   = ST_PRESSED;
                    gen_valid = 1'b1;
                    gen_code  = EV_PRESS;
                end
            end
            ST_PRESSED: begin
                if (fall) begin
                    state_d   = ST_IDLE;
                    gen_valid = 1'b1;
                    gen_code  = EV_RELEASE;
                end else if (tmr_tc) begin
                    state_d   = ST_LONG_HELD;
                    tmr_clear = 1'b1;
                    gen_valid = 1'b1;
                    gen_code  = EV_LONG;
                end else begin
                    tmr_enable = 1'b1;
                end
            end
            ST_LONG_HELD: begin
                if (fall) begin
                    state_d   = ST_IDLE;
                    gen_valid = 1'b1;
                    gen_code  = EV_RELEASE;
                end
`ifdef BTN_EVENT_REPEAT_EN
                else if (tmr_tc) begin
                    tmr_clear = 1'b1;
                    gen_valid = 1'b1;
                    gen_code  = EV_REPEAT;
                end else begin
                    tmr_enable = 1'b1;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // A pop and a push at the same edge let the new event replace the consumed one.
    always_comb begin
        ev_valid_d = ev_valid_q;
        ev_code_d  = ev_code_q;
        overflow_d = overflow_q;
        if (gen_valid && (!ev_valid_q || event_ready)) begin
            ev_valid_d = 1'b1;
            ev_code_d  = gen_code;
        end else begin
            if (ev_valid_q && event_ready) begin
                ev_valid_d = 1'b0;
            end
            if (gen_valid) begin
                overflow_d = 1'b1;
            end
        end
        pressed_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            db_prev_q  <= 1'b0;
            state_q    <= ST_IDLE;
            ev_valid_q <= 1'b0;
            ev_code_q  <= EV_PRESS;
            pressed_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            db_prev_q  <= db_in;
            state_q    <= state_d;
            ev_valid_q <= ev_valid_d;
            ev_code_q  <= ev_code_d;
            pressed_q  <= pressed_d;
            overflow_q <= overflow_d;
        end
    end

    assign event_valid = ev_valid_q;
    assign event_code  = ev_code_q;
    assign pressed     = pressed_q;
    assign overflow    = overflow_q;

endmodule

// File: doc/button_event_decoder.md
# button_event_decoder

Consumes the clean, debounced button level and turns it into discrete, handshaked events: PRESS, RELEASE, LONG (held past a threshold) and REPEAT (auto-repeat while held). It sits between the push-button debouncer output and the processor control logic (single-step, mode select), so that logic reads one event per user action instead of polling a level. Events are held in a one-entry buffer until the consumer acknowledges them.

## Interface
- LONG_CYCLES, 19_000_000: hold time in clk cycles before LONG fires (0.5 s at 38 MHz); legal range 2..2^CNT_W-1.
- REPEAT_CYCLES, 3_800_000: period in clk cycles between REPEAT events after LONG; legal range 2..2^CNT_W-1.
- CNT_W, 25: hold-counter width.
- clk  input  1  clock.
- n_reset  input  1  reset, synchronous, active-low.
- db_in  input  1  debounced button level, 1 = pressed; already synchronous to clk.
- event_ready  input  1  consumer accepts the buffered event this cycle.
- event_valid  output  1  buffer holds an event.
- event_code  output  2  0 PRESS, 1 RELEASE, 2 LONG, 3 REPEAT; meaningful only while event_valid = 1.
- pressed  output  1  registered: FSM not in IDLE.
- overflow  output  1  sticky: an event was dropped because the buffer was full.

## Operation
- Reset (n_reset = 0 at a clk edge): FSM -> IDLE; counter, db_prev, event_valid, event_code, pressed, overflow -> 0. Reset mid-hold discards the hold and any buffered event; no RELEASE is generated.
- Edge detect: db_prev <= db_in every cycle; rise = db_in & ~db_prev; fall = ~db_in & db_prev.
- FSM states IDLE, PRESSED, LONG_HELD.
  - IDLE: on rise -> PRESSED, counter <= 0, generate PRESS.
  - PRESSED: on fall -> IDLE, generate RELEASE. Else if counter == LONG_CYCLES-1 -> LONG_HELD, counter <= 0, generate LONG. Else counter + 1.
  - LONG_HELD: on fall -> IDLE, generate RELEASE. Else if REPEAT enabled and counter == REPEAT_CYCLES-1 -> counter <= 0, generate REPEAT. Else counter + 1, saturating at all-ones.
- Fall has priority over a terminal count in the same cycle: only RELEASE is generated.
- Counter compares are unsigned at CNT_W bits. The counter never wraps.
- Buffer (one entry):
  - A generated event is written when the buffer is empty, or when it is full and event_ready = 1 in the same cycle (pop and push together; the new event replaces the old).
  - If the buffer is full, event_ready = 0 and a new event is generated: the new event is dropped, the held event is unchanged, and overflow <= 1. overflow clears only on reset.
  - event_ready while event_valid = 0 is ignored.
  - event_code is stable while event_valid = 1 and no pop occurs.

## Timing
- Cycle t: db_in first samples 1. Cycle t+1: event_valid = 1, event_code = PRESS, pressed = 1. Latency is 1 clk.
- A press held continuously from cycle t gives LONG visible at t+1+LONG_CYCLES.
- REPEAT events are visible every REPEAT_CYCLES cycles after LONG.
- Release sampled at cycle r gives RELEASE visible at r+1; pressed = 0 at r+1.
- Handshake: the transfer occurs at a clk edge where event_valid & event_ready = 1. event_valid falls the next cycle unless a new event is written at that same edge.
- Minimum glitch width of db_in: 1 cycle. A 1-cycle pulse gives PRESS then RELEASE on consecutive cycles; RELEASE is dropped with overflow if PRESS is not consumed.

## Configuration
- BTN_EVENT_REPEAT_EN defined: REPEAT generation in LONG_HELD as above.
- BTN_EVENT_REPEAT_EN undefined: LONG_HELD only waits for fall, and the counter is frozen. Code 3 is never produced. REPEAT_CYCLES is accepted but unused.

## Structure
- Package btn_event_pkg holds the event-code constants (EV_PRESS=0, EV_RELEASE=1, EV_LONG=2, EV_REPEAT=3) and the FSM state encoding (IDLE=0, PRESSED=1, LONG_HELD=2).
- One sub-module is natural: btn_hold_timer (clear, enable, terminal-value input, terminal-count output, saturating CNT_W counter). The FSM, edge detect and buffer stay in the top.

## Test plan
Benches use LONG_CYCLES=8, REPEAT_CYCLES=4, CNT_W=8, event_ready held at 1 unless stated.
- Reset: hold n_reset=0 for 3 cycles with db_in=1 -> all outputs 0. Release reset with db_in=1 -> PRESS at the cycle after the first sample where db_prev=0 (i.e. one cycle later).
- Short press: db_in high for 5 cycles -> PRESS one cycle after rise, RELEASE one cycle after fall, no LONG, overflow=0.
- Long hold with REPEAT enabled: db_in high for 20 cycles -> PRESS at t+1, LONG at t+9, REPEAT at t+13 and t+17, then RELEASE at fall+1.
- Long hold with BTN_EVENT_REPEAT_EN undefined: same stimulus -> PRESS, LONG, RELEASE only.
- Backpressure: event_ready=0, 1-cycle db_in pulse -> event_valid=1, code PRESS held, RELEASE dropped, overflow=1. Then event_ready=1 -> PRESS consumed, event_valid=0 next cycle.
- Priority and reset mid-hold: fall coincident with count 7 -> RELEASE only. Separately, n_reset=0 at count 4 -> no RELEASE, pressed=0, and a new press after reset gives PRESS.
